// File: rtl/wash_cycle_controller.sv
// Wash phase sequencer: walks multi_phase_timer through SOAK/WASH/RINSE/SPIN and decodes actuators.
// Optional per-phase watchdog enabled by defining CYCLE_WATCHDOG_EN.
`timescale 1ns/1ps
module wash_cycle_controller #(
    parameter int unsigned WDOG_LIMIT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       power_on,
    input  logic       mode1,
    input  logic       mode2,
    input  logic       mode3,
    input  logic       mode4,
    input  logic       timer_done,
    output logic       timer_enable,
    output logic [1:0] phase_sel,
    output logic [3:0] timer_mode,
    output logic       water_valve,
    output logic       drain_valve,
    output logic       motor_on,
    output logic       busy,
    output logic       cycle_done,
    output logic       mode_err,
    output logic       fault
);

    localparam int unsigned MODE_W = 4;
    localparam int unsigned WDOG_W = 32;
    localparam logic [MODE_W-1:0] MODE_SPIN = 4'b0001;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SOAK  = 3'd1,
        ST_WASH  = 3'd2,
        ST_RINSE = 3'd3,
        ST_SPIN  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [MODE_W-1:0]  mode_q;
    logic [MODE_W-1:0]  mode_in;
    logic               gap_q;
    logic               mode_err_q;
    logic               mode_onehot;
    logic               accept;
    logic               entering;
    logic               start_acc;
    logic               start_rej;
    logic               wdog_hit;

    function automatic logic is_phase(input state_t s);
        return (s == ST_SOAK) || (s == ST_WASH) || (s == ST_RINSE) || (s == ST_SPIN);
    endfunction

    assign mode_in     = {mode1, mode2, mode3, mode4};
    assign mode_onehot = (mode_in != '0) && ((mode_in & (mode_in - MODE_W'(1))) == '0);

    // Done pulses count only while the timer is actually running on mains power.
    assign accept    = timer_enable && power_on && timer_done;
    assign entering  = is_phase(state_d) && (state_d != state_q);
    assign start_acc = (state_q == ST_IDLE) && (state_d != ST_IDLE);
    assign start_rej = (state_q == ST_IDLE) && start && power_on && !abort && !mode_onehot;

`ifdef CYCLE_WATCHDOG_EN
    localparam bit WDOG_EN = 1'b1;
    logic [WDOG_W-1:0] wdog_q;

    assign wdog_hit = timer_enable && power_on && (wdog_q == WDOG_W'(WDOG_LIMIT - 1));

    // Enabled-cycle counter, restarted on every phase entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= '0;
        end else if (entering) begin
            wdog_q <= '0;
        end else if (timer_enable && power_on) begin
            wdog_q <= wdog_q + WDOG_W'(1);
        end
    end
`else
    localparam bit WDOG_EN = 1'b0;
    logic [WDOG_W-1:0] unused_wdog_limit;

    assign wdog_hit          = 1'b0;
    assign unused_wdog_limit = WDOG_W'(WDOG_LIMIT);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort wins over everything; loss of mains freezes the sequence in place.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else if (power_on) begin
            case (state_q)
                ST_IDLE: begin
                    if (start && mode_onehot) begin
                        state_d = (mode_in == MODE_SPIN) ? ST_SPIN : ST_SOAK;
                    end
                end
                ST_SOAK: begin
                    if (accept)        state_d = ST_WASH;
                    else if (wdog_hit) state_d = ST_ERROR;
                end
                ST_WASH: begin
                    if (accept)        state_d = ST_RINSE;
                    else if (wdog_hit) state_d = ST_ERROR;
                end
                ST_RINSE: begin
                    if (accept)        state_d = ST_SPIN;
                    else if (wdog_hit) state_d = ST_ERROR;
                end
                ST_SPIN: begin
                    if (accept)        state_d = ST_DONE;
                    else if (wdog_hit) state_d = ST_ERROR;
                end
                ST_DONE:  state_d = ST_IDLE;
                ST_ERROR: state_d = ST_ERROR;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Gap flag holds the timer disabled for one powered cycle after each phase entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= '0;
            gap_q      <= 1'b0;
            mode_err_q <= 1'b0;
        end else begin
            mode_err_q <= start_rej;
            if (start_acc) begin
                mode_q <= mode_in;
            end
            if (entering) begin
                gap_q <= 1'b1;
            end else if (power_on || !is_phase(state_d)) begin
                gap_q <= 1'b0;
            end
        end
    end

    always_comb begin
        phase_sel    = 2'b00;
        busy         = 1'b0;
        water_valve  = 1'b0;
        drain_valve  = 1'b0;
        motor_on     = 1'b0;
        cycle_done   = 1'b0;
        fault        = 1'b0;
        timer_enable = 1'b0;
        case (state_q)
            ST_SOAK: begin
                phase_sel   = 2'b00;
                busy        = 1'b1;
                water_valve = power_on;
            end
            ST_WASH: begin
                phase_sel = 2'b01;
                busy      = 1'b1;
                motor_on  = power_on;
            end
            ST_RINSE: begin
                phase_sel   = 2'b10;
                busy        = 1'b1;
                water_valve = power_on;
                motor_on    = power_on;
            end
            ST_SPIN: begin
                phase_sel   = 2'b11;
                busy        = 1'b1;
                motor_on    = power_on;
                drain_valve = power_on;
            end
            ST_DONE:  cycle_done = 1'b1;
            ST_ERROR: fault      = WDOG_EN;
            default:  ;
        endcase
        timer_enable = busy && !gap_q;
    end

    assign timer_mode = mode_q;
    assign mode_err   = mode_err_q;

endmodule

// File: tb/tb_wash_cycle_controller.sv
// Directed bench for wash_cycle_controller with a behavioural multi_phase_timer model.
`timescale 1ns/1ps
module tb_wash_cycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       power_on;
    logic       mode1, mode2, mode3, mode4;
    logic       timer_done;
    logic       timer_enable;
    logic [1:0] phase_sel;
    logic [3:0] timer_mode;
    logic       water_valve, drain_valve, motor_on;
    logic       busy, cycle_done, mode_err, fault;

    int n_checks = 0;
    int n_fail   = 0;

    int occ[4];
    int total, gap_bad, act_bad, order_bad, hold_bad;
    int tcnt;
    bit suppress_done = 1'b0;

    always #5 clk = ~clk;

    wash_cycle_controller #(.WDOG_LIMIT(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .power_on     (power_on),
        .mode1        (mode1),
        .mode2        (mode2),
        .mode3        (mode3),
        .mode4        (mode4),
        .timer_done   (timer_done),
        .timer_enable (timer_enable),
        .phase_sel    (phase_sel),
        .timer_mode   (timer_mode),
        .water_valve  (water_valve),
        .drain_valve  (drain_valve),
        .motor_on     (motor_on),
        .busy         (busy),
        .cycle_done   (cycle_done),
        .mode_err     (mode_err),
        .fault        (fault)
    );

    // Timer limits per mode and phase (Quick, Normal, Heavy, Spin-only).
    function automatic int phase_limit(input logic [3:0] m, input logic [1:0] p);
        case (m)
            4'b1000: case (p) 2'b00: return 50; 2'b01: return 100; 2'b10: return 80; default: return 55; endcase
            4'b0100: case (p) 2'b00: return 60; 2'b01: return 200; 2'b10: return 90; default: return 70; endcase
            4'b0010: case (p) 2'b00: return 80; 2'b01: return 300; 2'b10: return 100; default: return 90; endcase
            default: return 40;
        endcase
    endfunction

    // Timer model: clears while disabled, pauses without power, pulses done after limit+1 enabled edges.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt       <= 0;
            timer_done <= 1'b0;
        end else if (power_on) begin
            if (!timer_enable) begin
                tcnt       <= 0;
                timer_done <= 1'b0;
            end else if (tcnt == phase_limit(timer_mode, phase_sel)) begin
                tcnt       <= 0;
                timer_done <= !suppress_done;
            end else begin
                tcnt       <= tcnt + 1;
                timer_done <= 1'b0;
            end
        end
    end

    task automatic set_mode(input logic [3:0] m);
        {mode1, mode2, mode3, mode4} = m;
    endtask

    task automatic pulse_start(input logic [3:0] m);
        set_mode(m);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Walks one busy run sample by sample, tallying phase occupancy and protocol violations.
    task automatic measure_cycle(input logic [3:0] m, input int drop_at, input int drop_len, input int budget);
        logic [1:0] prev;
        bit   first, dropped;
        int   off_left;
        logic ew, em, ed;
        occ = '{default: 0};
        total = 0; gap_bad = 0; act_bad = 0; order_bad = 0; hold_bad = 0;
        first = 1'b1; dropped = 1'b0; off_left = 0; prev = 2'b00;
        while (busy === 1'b1 && total < budget) begin
            if (first || phase_sel !== prev) begin
                if (timer_enable !== 1'b0) gap_bad++;
                if (first && phase_sel !== ((m == 4'b0001) ? 2'b11 : 2'b00)) order_bad++;
                if (!first && phase_sel !== 2'(prev + 2'd1)) order_bad++;
            end
            ew = power_on && (phase_sel == 2'b00 || phase_sel == 2'b10);
            em = power_on && (phase_sel != 2'b00);
            ed = power_on && (phase_sel == 2'b11);
            if (water_valve !== ew || motor_on !== em || drain_valve !== ed) act_bad++;
            if (!power_on && timer_enable !== 1'b1) hold_bad++;
            occ[phase_sel]++;
            total++;
            prev  = phase_sel;
            first = 1'b0;
            if (off_left > 0) begin
                off_left--;
                if (off_left == 0) power_on = 1'b1;
            end else if (!dropped && drop_at >= 0 && phase_sel == 2'b01 && occ[1] == drop_at) begin
                power_on = 1'b0;
                off_left = drop_len;
                dropped  = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; abort = 1'b0; power_on = 1'b1;
        set_mode(4'b0000);
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (phase_sel !== 2'b00) begin n_fail++; $display("FAIL reset_phase: got %b expected 00", phase_sel); end
        n_checks++; if (timer_mode !== 4'b0000) begin n_fail++; $display("FAIL reset_mode: got %b expected 0000", timer_mode); end
        n_checks++; if ({timer_enable, water_valve, drain_valve, motor_on, cycle_done, mode_err, fault} !== 7'b0)
            begin n_fail++; $display("FAIL reset_outs: got %b expected 0000000",
                {timer_enable, water_valve, drain_valve, motor_on, cycle_done, mode_err, fault}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_quick;
        pulse_start(4'b1000);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL quick_busy_at_start: got %b expected 1", busy); end
        n_checks++; if (timer_mode !== 4'b1000) begin n_fail++; $display("FAIL quick_mode: got %b expected 1000", timer_mode); end
        measure_cycle(4'b1000, -1, 0, 1000);
        n_checks++; if (total !== 297) begin n_fail++; $display("FAIL quick_total: got %0d expected 297", total); end
        n_checks++; if (occ[0] !== 53) begin n_fail++; $display("FAIL quick_soak: got %0d expected 53", occ[0]); end
        n_checks++; if (occ[1] !== 103) begin n_fail++; $display("FAIL quick_wash: got %0d expected 103", occ[1]); end
        n_checks++; if (occ[2] !== 83) begin n_fail++; $display("FAIL quick_rinse: got %0d expected 83", occ[2]); end
        n_checks++; if (occ[3] !== 58) begin n_fail++; $display("FAIL quick_spin: got %0d expected 58", occ[3]); end
        n_checks++; if (gap_bad !== 0) begin n_fail++; $display("FAIL quick_gap: got %0d bad expected 0", gap_bad); end
        n_checks++; if (order_bad !== 0) begin n_fail++; $display("FAIL quick_order: got %0d bad expected 0", order_bad); end
        n_checks++; if (act_bad !== 0) begin n_fail++; $display("FAIL quick_actuators: got %0d bad expected 0", act_bad); end
        n_checks++; if (cycle_done !== 1'b1) begin n_fail++; $display("FAIL quick_done: got %b expected 1", cycle_done); end
        @(negedge clk);
        n_checks++; if (cycle_done !== 1'b0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL quick_idle: got done=%b busy=%b expected 0 0", cycle_done, busy); end
    endtask

    task automatic test_spin_only;
        pulse_start(4'b0001);
        measure_cycle(4'b0001, -1, 0, 200);
        n_checks++; if (total !== 43) begin n_fail++; $display("FAIL spin_total: got %0d expected 43", total); end
        n_checks++; if (occ[3] !== 43) begin n_fail++; $display("FAIL spin_occ: got %0d expected 43", occ[3]); end
        n_checks++; if (order_bad !== 0 || gap_bad !== 0)
            begin n_fail++; $display("FAIL spin_order: got order=%0d gap=%0d expected 0 0", order_bad, gap_bad); end
        n_checks++; if (act_bad !== 0) begin n_fail++; $display("FAIL spin_actuators: got %0d bad expected 0", act_bad); end
        n_checks++; if (cycle_done !== 1'b1) begin n_fail++; $display("FAIL spin_done: got %b expected 1", cycle_done); end
        @(negedge clk);
    endtask

    task automatic test_power_loss;
        pulse_start(4'b0100);
        measure_cycle(4'b0100, 50, 20, 1000);
        n_checks++; if (occ[1] !== 223) begin n_fail++; $display("FAIL pwr_wash: got %0d expected 223", occ[1]); end
        n_checks++; if (total !== 452) begin n_fail++; $display("FAIL pwr_total: got %0d expected 452", total); end
        n_checks++; if (occ[2] !== 93 || occ[3] !== 73)
            begin n_fail++; $display("FAIL pwr_later: got rinse=%0d spin=%0d expected 93 73", occ[2], occ[3]); end
        n_checks++; if (act_bad !== 0) begin n_fail++; $display("FAIL pwr_actuators: got %0d bad expected 0", act_bad); end
        n_checks++; if (hold_bad !== 0) begin n_fail++; $display("FAIL pwr_enable_hold: got %0d bad expected 0", hold_bad); end
        n_checks++; if (cycle_done !== 1'b1) begin n_fail++; $display("FAIL pwr_done: got %b expected 1", cycle_done); end
        @(negedge clk);
    endtask

    task automatic test_invalid_mode;
        pulse_start(4'b1100);
        n_checks++; if (mode_err !== 1'b1) begin n_fail++; $display("FAIL inv_err_pulse: got %b expected 1", mode_err); end
        n_checks++; if (busy !== 1'b0 || timer_enable !== 1'b0)
            begin n_fail++; $display("FAIL inv_idle: got busy=%b en=%b expected 0 0", busy, timer_enable); end
        n_checks++; if (timer_mode !== 4'b0100) begin n_fail++; $display("FAIL inv_mode_kept: got %b expected 0100", timer_mode); end
        @(negedge clk);
        n_checks++; if (mode_err !== 1'b0) begin n_fail++; $display("FAIL inv_err_width: got %b expected 0", mode_err); end
        power_on = 1'b0;
        pulse_start(4'b1000);
        power_on = 1'b1;
        n_checks++; if (busy !== 1'b0 || mode_err !== 1'b0)
            begin n_fail++; $display("FAIL nopower_start: got busy=%b err=%b expected 0 0", busy, mode_err); end
        @(negedge clk);
    endtask

    task automatic test_abort;
        bit found;
        int spin_seen;
        found = 1'b0;
        spin_seen = 0;
        pulse_start(4'b1000);
        for (int i = 0; i < 400 && !found; i++) begin
            if (phase_sel === 2'b10 && timer_done === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL abort_reach_rinse_done: got %b expected 1", found); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0 || phase_sel !== 2'b00)
            begin n_fail++; $display("FAIL abort_idle: got busy=%b phase=%b expected 0 00", busy, phase_sel); end
        n_checks++; if ({timer_enable, water_valve, drain_valve, motor_on, cycle_done, fault} !== 6'b0)
            begin n_fail++; $display("FAIL abort_outs: got %b expected 000000",
                {timer_enable, water_valve, drain_valve, motor_on, cycle_done, fault}); end
        for (int i = 0; i < 5; i++) begin
            if (busy !== 1'b0 || phase_sel === 2'b11) spin_seen++;
            @(negedge clk);
        end
        n_checks++; if (spin_seen !== 0) begin n_fail++; $display("FAIL abort_no_spin: got %0d bad expected 0", spin_seen); end
    endtask

    task automatic test_async_reset;
        pulse_start(4'b0100);
        repeat (30) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL arst_pre_busy: got %b expected 1", busy); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || phase_sel !== 2'b00 || timer_mode !== 4'b0000)
            begin n_fail++; $display("FAIL arst_state: got busy=%b phase=%b mode=%b expected 0 00 0000",
                busy, phase_sel, timer_mode); end
        n_checks++; if ({timer_enable, water_valve, drain_valve, motor_on} !== 4'b0)
            begin n_fail++; $display("FAIL arst_outs: got %b expected 0000",
                {timer_enable, water_valve, drain_valve, motor_on}); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

`ifdef CYCLE_WATCHDOG_EN
    task automatic test_watchdog;
        int lost;
        lost = 0;
        suppress_done = 1'b1;
        pulse_start(4'b0100);
        measure_cycle(4'b0100, -1, 0, 300);
        n_checks++; if (total !== 65 || occ[0] !== 65)
            begin n_fail++; $display("FAIL wdog_occ: got total=%0d soak=%0d expected 65 65", total, occ[0]); end
        n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL wdog_fault: got %b expected 1", fault); end
        n_checks++; if ({timer_enable, water_valve, drain_valve, motor_on} !== 4'b0)
            begin n_fail++; $display("FAIL wdog_outs: got %b expected 0000",
                {timer_enable, water_valve, drain_valve, motor_on}); end
        for (int i = 0; i < 10; i++) begin
            if (fault !== 1'b1) lost++;
            @(negedge clk);
        end
        n_checks++; if (lost !== 0) begin n_fail++; $display("FAIL wdog_sticky: got %0d bad expected 0", lost); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL wdog_abort: got %b expected 0", fault); end
        suppress_done = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_quick();
        test_spin_only();
        test_power_loss();
        test_invalid_mode();
        test_abort();
        test_async_reset();
`ifdef CYCLE_WATCHDOG_EN
        test_watchdog();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wash_cycle_controller.md
# wash_cycle_controller

Phase-sequencing controller that drives `multi_phase_timer` and consumes its `timer_done` pulses. It latches the front-panel wash mode on `start` and walks the timer through SOAK → WASH → RINSE → SPIN, or SPIN only for spin-only mode. It drives `phase_sel`, `timer_enable` and the latched mode lines into the timer, and decodes motor and valve actuator commands from its state.

## Interface
- `WDOG_LIMIT`, default 1024: enabled cycles allowed per phase before fault; only used with `CYCLE_WATCHDOG_EN`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  level; sampled in IDLE only.
- `abort`  in  1  level; returns to IDLE from any state.
- `power_on`  in  1  0 = mains lost: freeze and gate actuators; also routed to timer.
- `mode1..mode4`  in  1 each  front-panel mode: Quick, Normal, Heavy, Spin-only.
- `timer_done`  in  1  one-cycle registered pulse from the timer.
- `timer_enable`  out  1  to timer `enable`.
- `phase_sel`  out  2  to timer; SOAK=00, WASH=01, RINSE=10, SPIN=11.
- `timer_mode`  out  4  latched `{mode1,mode2,mode3,mode4}` to timer mode inputs.
- `water_valve`, `drain_valve`, `motor_on`  out  1 each  actuator commands.
- `busy`  out  1  high in SOAK/WASH/RINSE/SPIN.
- `cycle_done`  out  1  one-cycle pulse in DONE.
- `mode_err`  out  1  one-cycle pulse when `start` is rejected.
- `fault`  out  1  high in ERROR.

## Operation
- States: IDLE, SOAK, WASH, RINSE, SPIN, DONE, ERROR.
- Reset state:
  - State is IDLE.
  - `mode_q` = 0000 and `gap_q` = 0.
  - All outputs are 0, including `phase_sel` = 00 and `timer_mode` = 0000.
- Start in IDLE, when `start` = 1 and `power_on` = 1:
  - Mode one-hot: latch it into `mode_q`. Go to SOAK, or to SPIN if the mode is 0001.
  - Mode not one-hot: stay in IDLE and pulse `mode_err` next cycle.
- Phase order:
  - Quick/Normal/Heavy: SOAK→WASH→RINSE→SPIN→DONE.
  - Spin-only: SPIN→DONE.
- Gap cycle: entering any phase state sets `gap_q` = 1 for exactly one enabled cycle.
  - `timer_enable` = in-phase AND NOT `gap_q`.
  - This clears the timer counter between phases.
- Advance: `timer_done` is accepted only when `timer_enable` = 1 and `power_on` = 1. Acceptance moves to the next phase on that edge.
- DONE lasts one cycle (`cycle_done` = 1), then IDLE. `start` is ignored in DONE.
- Actuators (Moore, decoded from state, ANDed with `power_on`):
  - SOAK: `water_valve`.
  - WASH: `motor_on`.
  - RINSE: `water_valve` and `motor_on`.
  - SPIN: `motor_on` and `drain_valve`.
  - All other states: none.
- Power loss (`power_on` = 0):
  - State, `gap_q`, `mode_q` and the watchdog counter hold.
  - `timer_enable` holds its value; the timer pauses itself.
  - On restore, the sequence resumes exactly where it stopped; a pending gap cycle is still performed.
- `abort` has the highest priority after `rst`: any state goes to IDLE next edge, regardless of `start` or `timer_done`.
- `phase_sel` follows state and holds 00 outside the phase states.
- `timer_mode` = `mode_q`; it changes only at an accepted start.

## Timing
- Phase occupancy for timer limit N, with no power loss: N+3 cycles.
  - 1 gap cycle.
  - N+1 enabled edges until the timer registers `timer_done`.
  - 1 cycle to accept it.
- `start` sampled at edge S → `busy` = 1 and SOAK from S.
- Quick wash (50/100/80/55): 53+103+83+58 = 297 busy cycles, then 1 DONE cycle.
- Spin-only (40): 43 busy cycles.
- `mode_err` goes high 1 cycle after the rejecting edge and lasts 1 cycle.
- `rst` asserted mid-cycle → IDLE and all outputs 0 immediately (asynchronous).

## Configuration
- `CYCLE_WATCHDOG_EN` defined:
  - A 32-bit counter clears on phase entry.
  - It increments on each cycle with `timer_enable` = 1 and `power_on` = 1.
  - Reaching `WDOG_LIMIT` before `timer_done` → ERROR.
  - ERROR: `fault` = 1, all actuators 0, `timer_enable` = 0. Only `abort` or `rst` leaves it.
- `CYCLE_WATCHDOG_EN` undefined: no counter; ERROR is unreachable and `fault` is tied 0.

## Test plan
- Quick wash: mode 1000, pulse `start` → phases 00,01,10,11 for 53/103/83/58 cycles, `timer_enable` low on each phase's first cycle, then `cycle_done` pulse and IDLE.
- Spin-only: mode 0001, `start` → SPIN only, `motor_on` and `drain_valve` for 43 cycles, then `cycle_done`.
- Invalid mode: mode 1100, `start` → stays IDLE, `mode_err` one-cycle pulse, `timer_enable` 0.
- Power loss: drop `power_on` 20 cycles mid-WASH → actuators 0 and state held; WASH occupancy is 203+20 cycles, sequence otherwise unchanged.
- Abort: assert `abort` in RINSE, same cycle as `timer_done` → IDLE next edge, no SPIN entered, all outputs 0.
- Watchdog (with `CYCLE_WATCHDOG_EN`, `WDOG_LIMIT` = 64): Normal wash, `timer_done` held 0 → ERROR after 64 enabled cycles, `fault` = 1 until `abort`.
